mem_req_arb: RTL

N-channel memory request arbiter with valid/ready handshakes, a registered request slot, per-requester ID tagging and response routing. It sits between the core's memory clients (instruction fetch, data cache, further clients) and the single memory request port. Grants are round-robin by default and fixed-priority when so configured. Memory responses are steered back to the requester encoded in the response ID.

---
 rtl/mem_req_arb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_req_arb.sv
// N-channel memory request arbiter: registered request slot with {src,seq} ID tagging and
// one-cycle registered response routing. Define ARB_FIXED_PRIO_EN for fixed priority (default: round-robin).
module mem_req_arb #(
    parameter  int PA_WIDTH   = 32,
    parameter  int LINE_BYTES = 64,
    parameter  int NUM_REQ    = 2,
    parameter  int SEQ_WIDTH  = 4,
    localparam int DW         = LINE_BYTES * 8,
    localparam int SRC_WIDTH  = $clog2(NUM_REQ),
    localparam int ID_WIDTH   = SRC_WIDTH + SEQ_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ*PA_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DW-1:0]       i_req_data,
    input  logic [NUM_REQ-1:0]          i_req_write,
    output logic                        o_mem_valid,
    input  logic                        i_mem_ready,
    output logic [PA_WIDTH-1:0]         o_mem_addr,
    output logic [DW-1:0]               o_mem_data,
    output logic                        o_mem_write,
    output logic [ID_WIDTH-1:0]         o_mem_id,
    input  logic                        i_resp_valid,
    input  logic [ID_WIDTH-1:0]         i_resp_id,
    input  logic [DW-1:0]               i_resp_data,
    output logic [NUM_REQ-1:0]          o_resp_valid,
    output logic [DW-1:0]               o_resp_data
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t                r_state, w_state_next;
    logic [SRC_WIDTH-1:0]  r_rr_ptr, w_ptr_next;
    logic [SRC_WIDTH-1:0]  r_src;
    logic [SEQ_WIDTH-1:0]  r_seq;
    logic [PA_WIDTH-1:0]   r_addr;
    logic [DW-1:0]         r_data;
    logic                  r_write;
    logic [NUM_REQ-1:0]    r_resp_valid;
    logic [DW-1:0]         r_resp_data;

    logic                  w_acc, w_hs, w_hi_found;
    logic [SRC_WIDTH-1:0]  w_hi, w_lo, w_win;
    logic [SRC_WIDTH-1:0]  w_resp_src;
    logic                  w_resp_ok;
    logic [NUM_REQ-1:0]    w_resp_onehot;

    // Lowest valid index at/above the pointer, falling back to the lowest valid index overall (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (i_req_valid[j]) begin
                w_lo = SRC_WIDTH'(j);
                if (j >= int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi       = SRC_WIDTH'(j);
                end
            end
        end
        w_win = w_hi_found ? w_hi : w_lo;
    end

`ifdef ARB_FIXED_PRIO_EN
    assign w_ptr_next = '0;
`else
    assign w_ptr_next = (w_win == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`endif

    assign w_acc = rst_n && (!o_mem_valid || i_mem_ready) && (|i_req_valid);
    assign w_hs  = o_mem_valid && i_mem_ready;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign o_req_ready[gi]   = w_acc && (w_win == SRC_WIDTH'(gi));
            assign w_resp_onehot[gi] = (w_resp_src == SRC_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_acc) w_state_next = S_FULL;
            S_FULL:  if (!w_acc && i_mem_ready) w_state_next = S_EMPTY;
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        o_mem_valid = (r_state == S_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_src    <= '0;
            r_seq    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_write  <= 1'b0;
        end else begin
            if (w_hs) r_seq <= r_seq + 1'b1;
            if (w_acc) begin
                r_rr_ptr <= w_ptr_next;
                r_src    <= w_win;
                r_addr   <= i_req_addr[int'(w_win) * PA_WIDTH +: PA_WIDTH];
                r_data   <= i_req_data[int'(w_win) * DW +: DW];
                r_write  <= i_req_write[w_win];
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_data  = r_data;
    assign o_mem_write = r_write;
    assign o_mem_id    = {r_src, r_seq};

    // Responses whose source field names a nonexistent requester are dropped.
    assign w_resp_src = i_resp_id[ID_WIDTH-1 -: SRC_WIDTH];
    assign w_resp_ok  = i_resp_valid && ({1'b0, w_resp_src} < (SRC_WIDTH + 1)'(NUM_REQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_resp_ok ? w_resp_onehot : '0;
            if (w_resp_ok) r_resp_data <= i_resp_data;
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = r_resp_data;

endmodule
